// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-path controller driving a SIPO data_in/shift pair
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic baud_tick,
  output logic data_out,
  output logic shift,
  output logic rx_done,
  output logic frame_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  logic par;
  logic par_err;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;
`endif

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [3:0]    bcnt;
  logic          rx_meta;
  logic          rx_s;

  // Preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      data_out  <= 1'b0;
      shift     <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par       <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      shift     <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            tcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tcnt == T_HALF) begin
              tcnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                par   <= 1'b0;
`endif
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tcnt == T_FULL) begin
              tcnt     <= '0;
              data_out <= rx_s;
              shift    <= 1'b1;
              bcnt     <= bcnt + 4'd1;
`ifdef UART_RX_PARITY_EN
              par      <= par ^ rx_s;
              if (bcnt == B_LAST) state <= PARITY;
`else
              if (bcnt == B_LAST) state <= STOP;
`endif
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            if (tcnt == T_FULL) begin
              tcnt    <= '0;
              par_err <= par ^ rx_s;
              state   <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (tcnt == T_FULL) begin
              tcnt <= '0;
              if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                frame_err <= par_err;
                rx_done   <= !par_err;
`else
                rx_done   <= 1'b1;
`endif
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK_WAIT;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        // A held-low line after a bad stop bit must not be taken as a new start.
        BRK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl
// Frames are built from data/stop/parity values; expected bits and outcomes come from the frame itself.
module tb_uart_rx_ctrl;
  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic baud_tick = 1'b0;
  logic data_out, shift, rx_done, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic got_bits[$];
  int   n_done    = 0;
  int   n_err     = 0;
  int   n_overlap = 0;
  int   div       = 0;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .baud_tick(baud_tick),
    .data_out(data_out), .shift(shift), .rx_done(rx_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      baud_tick = (div == TDIV - 1);
      div = (div + 1) % TDIV;
    end
  end

  always @(negedge clk) begin
    if (shift) got_bits.push_back(data_out);
    if (rx_done) n_done++;
    if (frame_err) n_err++;
    if (int'(shift) + int'(rx_done) + int'(frame_err) > 1) n_overlap++;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(int n);
    repeat (n) begin
      do @(posedge clk); while (!baud_tick);
    end
    #1;
  endtask

  task automatic send_bit(logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop, logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop);
  endtask

  function automatic logic frame_ok(logic [7:0] d, logic stop, logic pbit);
`ifdef UART_RX_PARITY_EN
    return stop && ((^d ^ pbit) == 1'b0);
`else
    return stop;
`endif
  endfunction

  task automatic expect_bits(string tag, int base, logic [7:0] d);
    for (int i = 0; i < DB; i++)
      if (got_bits.size() > base + i)
        check($sformatf("%s_bit%0d", tag, i), 32'(got_bits[base + i]), 32'(d[i]));
  endtask

  task automatic run_frame(string tag, logic [7:0] d, logic stop, logic pbit);
    int b0, d0, e0;
    logic ok;
    b0 = got_bits.size(); d0 = n_done; e0 = n_err;
    ok = frame_ok(d, stop, pbit);
    send_frame(d, stop, pbit);
    rx = 1'b1;
    wait_ticks(2);
    check({tag, "_nshift"}, 32'(got_bits.size() - b0), DB);
    expect_bits(tag, b0, d);
    check({tag, "_done"}, 32'(n_done - d0), ok ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(n_err - e0), ok ? 32'd0 : 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int b0, d0, e0;
    logic [7:0] d;
    logic stop, pbit;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 0);
    check("rst_shift", 32'(shift), 0);
    check("rst_rx_done", 32'(rx_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    wait_ticks(4);

    run_frame("a5", 8'hA5, 1'b1, ^8'hA5);

    b0 = got_bits.size(); d0 = n_done; e0 = n_err;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(OS);
    check("glitch_nshift", 32'(got_bits.size() - b0), 0);
    check("glitch_done", 32'(n_done - d0), 0);
    check("glitch_err", 32'(n_err - e0), 0);
    check("glitch_busy", 32'(busy), 0);

    b0 = got_bits.size(); d0 = n_done; e0 = n_err;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_ticks(40);
    check("brk_nshift", 32'(got_bits.size() - b0), DB);
    expect_bits("brk", b0, 8'h3C);
    check("brk_done", 32'(n_done - d0), 0);
    check("brk_err", 32'(n_err - e0), 1);
    check("brk_busy_held", 32'(busy), 1);
    rx = 1'b1;
    wait_ticks(4);
    check("brk_release", 32'(busy), 0);
    run_frame("after_brk", 8'h5A, 1'b1, ^8'h5A);

    b0 = got_bits.size(); d0 = n_done; e0 = n_err;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    wait_ticks(2);
    check("b2b_nshift", 32'(got_bits.size() - b0), 2 * DB);
    expect_bits("b2b0", b0, 8'h00);
    expect_bits("b2b1", b0 + DB, 8'hFF);
    check("b2b_done", 32'(n_done - d0), 2);
    check("b2b_err", 32'(n_err - e0), 0);

    b0 = got_bits.size(); d0 = n_done; e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    wait_ticks(2);
    check("mid_nshift", 32'(got_bits.size() - b0), 3);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_outs", {27'd0, data_out, shift, rx_done, frame_err, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    reset = 1'b1;
    wait_ticks(OS);
    check("mid_rst_done", 32'(n_done - d0), 0);
    check("mid_rst_err", 32'(n_err - e0), 0);
    run_frame("after_rst", 8'h81, 1'b1, ^8'h81);

`ifdef UART_RX_PARITY_EN
    run_frame("par_ok", 8'h07, 1'b1, 1'b1);
    run_frame("par_bad", 8'h07, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 25; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pbit = ^d ^ ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", k), d, stop, pbit);
    end

    check("pulse_overlap", 32'(n_overlap), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
